picorv32_axi_adapter: RTL and testbench

// - Bridges the PicoRV32 native memory interface to a single AXI4-Lite master port.
// - Sits inside picorv32_axi, between the core and the external AXI slave memory.
// - Handles one outstanding transfer at a time; no bursts, no IDs, no response codes.

---
 rtl/picorv32_axi_adapter_if.sv | 59 +++++
 rtl/picorv32_axi_adapter.sv | 99 +++++++++
 tb/tb_picorv32_axi_adapter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/picorv32_axi_adapter_if.sv
// Bundle of the PicoRV32 native memory port and the AXI4-Lite master port.
// The master modport is the adapter itself; the slave modport is the core plus AXI memory.
interface picorv32_axi_adapter_if;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   logic        mem_axi_awvalid;
   logic        mem_axi_awready;
   logic [31:0] mem_axi_awaddr;
   logic [2:0]  mem_axi_awprot;
   logic        mem_axi_wvalid;
   logic        mem_axi_wready;
   logic [31:0] mem_axi_wdata;
   logic [3:0]  mem_axi_wstrb;
   logic        mem_axi_bvalid;
   logic        mem_axi_bready;
   logic        mem_axi_arvalid;
   logic        mem_axi_arready;
   logic [31:0] mem_axi_araddr;
   logic [2:0]  mem_axi_arprot;
   logic        mem_axi_rvalid;
   logic        mem_axi_rready;
   logic [31:0] mem_axi_rdata;

   modport master (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata,
      output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
      input  mem_axi_awready,
      output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
      input  mem_axi_wready,
      input  mem_axi_bvalid,
      output mem_axi_bready,
      output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
      input  mem_axi_arready,
      input  mem_axi_rvalid, mem_axi_rdata,
      output mem_axi_rready
   );

   modport slave (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata,
      input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
      output mem_axi_awready,
      input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
      output mem_axi_wready,
      output mem_axi_bvalid,
      input  mem_axi_bready,
      input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
      output mem_axi_arready,
      output mem_axi_rvalid, mem_axi_rdata,
      input  mem_axi_rready
   );
endinterface

// File: rtl/picorv32_axi_adapter.sv
// PicoRV32 native memory interface to AXI4-Lite bridge, one transfer in flight.
// Optional macro AXI_RESP_REG_EN registers the B/R response (mem_ready one cycle later).
module picorv32_axi_adapter (
   input  logic                          clk,
   input  logic                          resetn,
   picorv32_axi_adapter_if.master        bus
);

   logic w_run;
   logic w_is_wr;
   logic w_resp_en;
   logic w_ready;
   logic w_xfer_done;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_ar_hs;
   logic r_ack_aw;
   logic r_ack_w;
   logic r_ack_ar;

   // resetn is active-high here: the request is masked while it is asserted
   assign w_run   = bus.mem_valid & ~resetn;
   assign w_is_wr = |bus.mem_wstrb;

   assign bus.mem_axi_awvalid = w_run &  w_is_wr & ~r_ack_aw;
   assign bus.mem_axi_wvalid  = w_run &  w_is_wr & ~r_ack_w;
   assign bus.mem_axi_arvalid = w_run & ~w_is_wr & ~r_ack_ar;
   assign bus.mem_axi_bready  = w_run &  w_is_wr & w_resp_en;
   assign bus.mem_axi_rready  = w_run & ~w_is_wr & w_resp_en;

   assign bus.mem_axi_awaddr = bus.mem_addr;
   assign bus.mem_axi_araddr = bus.mem_addr;
   assign bus.mem_axi_awprot = 3'b000;
   assign bus.mem_axi_arprot = bus.mem_instr ? 3'b100 : 3'b000;
   assign bus.mem_axi_wdata  = bus.mem_wdata;
   assign bus.mem_axi_wstrb  = bus.mem_wstrb;

   assign w_aw_hs = bus.mem_axi_awvalid & bus.mem_axi_awready;
   assign w_w_hs  = bus.mem_axi_wvalid  & bus.mem_axi_wready;
   assign w_ar_hs = bus.mem_axi_arvalid & bus.mem_axi_arready;

`ifdef AXI_RESP_REG_EN
   logic        r_done;
   logic [31:0] r_rdata;
   logic        w_b_hs;
   logic        w_r_hs;

   assign w_b_hs    = bus.mem_axi_bvalid & bus.mem_axi_bready;
   assign w_r_hs    = bus.mem_axi_rvalid & bus.mem_axi_rready;
   assign w_resp_en = ~r_done;
   assign w_ready   = w_run & r_done;
   assign bus.mem_rdata = r_rdata;

   // Response-seen flag; it also blocks a second B/R acceptance for this transfer
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_done <= 1'b0;
      end else if (!bus.mem_valid || w_xfer_done) begin
         r_done <= 1'b0;
      end else if (w_b_hs || w_r_hs) begin
         r_done <= 1'b1;
      end
   end

   // Read data captured on the R handshake
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_rdata <= 32'h0000_0000;
      end else if (w_r_hs) begin
         r_rdata <= bus.mem_axi_rdata;
      end
   end
`else
   assign w_resp_en     = 1'b1;
   assign w_ready       = w_run & (w_is_wr ? bus.mem_axi_bvalid : bus.mem_axi_rvalid);
   assign bus.mem_rdata = bus.mem_axi_rdata;
`endif

   assign bus.mem_ready = w_ready;
   assign w_xfer_done   = w_run & w_ready;

   // Address/data acceptance flags; dropping mem_valid abandons the transfer
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_ack_aw <= 1'b0;
         r_ack_w  <= 1'b0;
         r_ack_ar <= 1'b0;
      end else if (!bus.mem_valid || w_xfer_done) begin
         r_ack_aw <= 1'b0;
         r_ack_w  <= 1'b0;
         r_ack_ar <= 1'b0;
      end else begin
         if (w_aw_hs) r_ack_aw <= 1'b1;
         if (w_w_hs)  r_ack_w  <= 1'b1;
         if (w_ar_hs) r_ack_ar <= 1'b1;
      end
   end

endmodule

// File: tb/tb_picorv32_axi_adapter.sv
// Directed bench for picorv32_axi_adapter (default build, combinational response path).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_picorv32_axi_adapter;

   logic clk;
   logic resetn;
   int   n_tests;
   int   n_fail;

   picorv32_axi_adapter_if bus ();

   picorv32_axi_adapter dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle_axi();
      bus.mem_axi_awready = 1'b0;
      bus.mem_axi_wready  = 1'b0;
      bus.mem_axi_bvalid  = 1'b0;
      bus.mem_axi_arready = 1'b0;
      bus.mem_axi_rvalid  = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      resetn  = 1'b1;
      bus.mem_valid = 1'b0;
      bus.mem_instr = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      bus.mem_wstrb = 4'b0000;
      bus.mem_axi_rdata = 32'h0;
      idle_axi();

      // ---- in reset: request and responses must be masked
      settle();
      bus.mem_valid = 1'b1;
      bus.mem_axi_rvalid = 1'b1;
      bus.mem_axi_rdata  = 32'hDEAD_BEEF;
      #1;
      chk_eq("rst_arvalid", {31'b0, bus.mem_axi_arvalid}, 32'd0);
      chk_eq("rst_rready",  {31'b0, bus.mem_axi_rready},  32'd0);
      chk_eq("rst_ready",   {31'b0, bus.mem_ready},       32'd0);
      chk_eq("rst_rdata",   bus.mem_rdata, 32'hDEAD_BEEF);
      bus.mem_valid = 1'b0;
      idle_axi();
      settle();
      resetn = 1'b0;

      // ---- instruction fetch from 0x10
      settle();
      bus.mem_valid = 1'b1; bus.mem_instr = 1'b1; bus.mem_addr = 32'h0000_0010;
      bus.mem_wstrb = 4'b0000; bus.mem_axi_arready = 1'b1;
      #1;
      chk_eq("rd_arvalid", {31'b0, bus.mem_axi_arvalid}, 32'd1);
      chk_eq("rd_arprot",  {29'b0, bus.mem_axi_arprot},  32'd4);
      chk_eq("rd_araddr",  bus.mem_axi_araddr, 32'h0000_0010);
      chk_eq("rd_awvalid", {31'b0, bus.mem_axi_awvalid}, 32'd0);
      chk_eq("rd_ready0",  {31'b0, bus.mem_ready}, 32'd0);
      settle();
      bus.mem_axi_arready = 1'b0;
      bus.mem_axi_rvalid  = 1'b1; bus.mem_axi_rdata = 32'h0000_0013;
      #1;
      chk_eq("rd_arvalid_off", {31'b0, bus.mem_axi_arvalid}, 32'd0);
      chk_eq("rd_ready",       {31'b0, bus.mem_ready}, 32'd1);
      chk_eq("rd_rdata",       bus.mem_rdata, 32'h0000_0013);
      settle();
      bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; idle_axi();
      #1;
      chk_eq("rd_ready_end", {31'b0, bus.mem_ready}, 32'd0);

      // ---- write 0x10000000, AW two cycles ahead of W
      settle();
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h1000_0000;
      bus.mem_wdata = 32'h0000_0041; bus.mem_wstrb = 4'b1111;
      bus.mem_axi_awready = 1'b1;
      #1;
      chk_eq("wr1_awvalid", {31'b0, bus.mem_axi_awvalid}, 32'd1);
      chk_eq("wr1_wvalid",  {31'b0, bus.mem_axi_wvalid},  32'd1);
      chk_eq("wr1_arvalid", {31'b0, bus.mem_axi_arvalid}, 32'd0);
      chk_eq("wr1_awaddr",  bus.mem_axi_awaddr, 32'h1000_0000);
      chk_eq("wr1_wdata",   bus.mem_axi_wdata,  32'h0000_0041);
      chk_eq("wr1_bready",  {31'b0, bus.mem_axi_bready}, 32'd1);
      settle();
      bus.mem_axi_awready = 1'b0;
      #1;
      chk_eq("wr1_aw_drop", {31'b0, bus.mem_axi_awvalid}, 32'd0);
      chk_eq("wr1_w_hold1", {31'b0, bus.mem_axi_wvalid},  32'd1);
      settle();
      bus.mem_axi_wready = 1'b1;
      #1;
      chk_eq("wr1_w_hold2", {31'b0, bus.mem_axi_wvalid}, 32'd1);
      chk_eq("wr1_ready0",  {31'b0, bus.mem_ready}, 32'd0);
      settle();
      bus.mem_axi_wready = 1'b0; bus.mem_axi_bvalid = 1'b1;
      #1;
      chk_eq("wr1_w_drop", {31'b0, bus.mem_axi_wvalid}, 32'd0);
      chk_eq("wr1_ready",  {31'b0, bus.mem_ready}, 32'd1);
      settle();
      bus.mem_valid = 1'b0; idle_axi();

      // ---- write 123456789 to 0x20000000, AW and W together
      settle();
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h2000_0000;
      bus.mem_wdata = 32'h075B_CD15; bus.mem_wstrb = 4'b1111;
      bus.mem_axi_awready = 1'b1; bus.mem_axi_wready = 1'b1;
      #1;
      chk_eq("wr2_wdata", bus.mem_axi_wdata, 32'h075B_CD15);
      settle();
      bus.mem_axi_awready = 1'b0; bus.mem_axi_wready = 1'b0;
      #1;
      chk_eq("wr2_both_acked", {30'b0, bus.mem_axi_awvalid, bus.mem_axi_wvalid}, 32'd0);
      chk_eq("wr2_ready0",     {31'b0, bus.mem_ready}, 32'd0);
      settle();
      bus.mem_axi_bvalid = 1'b1;
      #1;
      chk_eq("wr2_ready", {31'b0, bus.mem_ready}, 32'd1);
      settle();
      bus.mem_axi_bvalid = 1'b0;
      #1;
      chk_eq("wr2_ready_once", {31'b0, bus.mem_ready}, 32'd0);
      chk_eq("wr2_flags_clr",  {31'b0, bus.mem_axi_awvalid}, 32'd1);
      bus.mem_valid = 1'b0;

      // ---- byte write to 0x103
      settle();
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h0000_0103;
      bus.mem_wdata = 32'hAB00_0000; bus.mem_wstrb = 4'b1000;
      #1;
      chk_eq("bw_wstrb",   {28'b0, bus.mem_axi_wstrb},  32'h8);
      chk_eq("bw_awaddr",  bus.mem_axi_awaddr, 32'h0000_0103);
      chk_eq("bw_awprot",  {29'b0, bus.mem_axi_awprot}, 32'd0);
      chk_eq("bw_arvalid", {31'b0, bus.mem_axi_arvalid}, 32'd0);

      // ---- mem_valid dropped after AW handshake abandons the flags
      bus.mem_axi_awready = 1'b1;
      settle();
      bus.mem_axi_awready = 1'b0; bus.mem_valid = 1'b0;
      settle();
      bus.mem_valid = 1'b1;
      #1;
      chk_eq("drop_aw_again", {31'b0, bus.mem_axi_awvalid}, 32'd1);
      bus.mem_valid = 1'b0;

      // ---- back-to-back read then write, mem_valid held
      settle();
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h0000_0200; bus.mem_wstrb = 4'b0000;
      bus.mem_axi_arready = 1'b1;
      #1;
      chk_eq("b2b_arprot", {29'b0, bus.mem_axi_arprot}, 32'd0);
      settle();
      bus.mem_axi_arready = 1'b0;
      bus.mem_axi_rvalid = 1'b1; bus.mem_axi_rdata = 32'hCAFE_BABE;
      #1;
      chk_eq("b2b_rdata", bus.mem_rdata, 32'hCAFE_BABE);
      chk_eq("b2b_ready", {31'b0, bus.mem_ready}, 32'd1);
      settle();
      bus.mem_axi_rvalid = 1'b0;
      bus.mem_addr = 32'h0000_0300; bus.mem_wdata = 32'h55; bus.mem_wstrb = 4'b1111;
      #1;
      chk_eq("b2b_awvalid", {31'b0, bus.mem_axi_awvalid}, 32'd1);
      chk_eq("b2b_wvalid",  {31'b0, bus.mem_axi_wvalid},  32'd1);
      chk_eq("b2b_arvalid", {31'b0, bus.mem_axi_arvalid}, 32'd0);
      bus.mem_axi_awready = 1'b1; bus.mem_axi_wready = 1'b1;
      settle();
      bus.mem_axi_awready = 1'b0; bus.mem_axi_wready = 1'b0; bus.mem_axi_bvalid = 1'b1;
      #1;
      chk_eq("b2b_wr_ready", {31'b0, bus.mem_ready}, 32'd1);
      settle();
      bus.mem_wstrb = 4'b0000; bus.mem_addr = 32'h0000_0400; idle_axi();
      #1;
      chk_eq("b2b_fresh_ar", {31'b0, bus.mem_axi_arvalid}, 32'd1);

      // ---- reset pulse after AR handshake, read still pending
      bus.mem_axi_arready = 1'b1;
      settle();
      bus.mem_axi_arready = 1'b0;
      #1;
      chk_eq("rr_ar_acked", {31'b0, bus.mem_axi_arvalid}, 32'd0);
      resetn = 1'b1;
      #1;
      chk_eq("rr_in_reset", {31'b0, bus.mem_axi_arvalid}, 32'd0);
      resetn = 1'b0;
      #1;
      chk_eq("rr_ar_reassert", {31'b0, bus.mem_axi_arvalid}, 32'd1);
      bus.mem_axi_arready = 1'b1;
      settle();
      bus.mem_axi_arready = 1'b0;
      bus.mem_axi_rvalid = 1'b1; bus.mem_axi_rdata = 32'h1234_5678;
      #1;
      chk_eq("rr_rdata", bus.mem_rdata, 32'h1234_5678);
      settle();
      bus.mem_valid = 1'b0; idle_axi();
      settle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
